// File: rtl/mem_pkg.sv
// Shared definitions for the nRisc data-memory responder.
//   mem_state_t : responder FSM states
//   MEM_ADDR_W  : default address width
//   MEM_DATA_W  : default data word width
//   WAIT_W      : width of the wait-state counter (supports 0..15)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } mem_state_t;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam int WAIT_W     = 4;

endpackage

// File: rtl/mem_array.sv
// Storage array for the data-memory responder.
// Synchronous write, registered read, asynchronous clear of every word.
// Ports:
//   clk_i    : clock (rising edge)
//   rst_ni   : asynchronous active-low clear of the array and read register
//   we_i     : write strobe, commits wdata_i to addr_i at the edge
//   re_i     : read strobe, loads rdata_o from addr_i at the edge
//   addr_i   : word address, indexes the array directly
//   wdata_i  : write data
//   rdata_o  : registered read data, holds until the next read
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] words;
  logic [DATA_W-1:0]            rdata_q;

  // One register per word so the whole array can be cleared by reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_q <= '0;
      end else if (we_i && (addr_i == ADDR_W'(g))) begin
        word_q <= wdata_i;
      end
    end

    assign words[g] = word_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= words[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the nRisc data-memory bus.
// Accepts one read or write request, waits WAIT_STATES cycles, performs the
// access and raises Pronto for one cycle. A held request is serviced once.
// Ports:
//   Clock       : clock (rising edge)
//   reset       : asynchronous active-low reset, also clears the array
//   EscMem      : write request, held until Pronto is seen
//   LerMem      : read request, held until Pronto is seen
//   Endereco    : access address
//   EscreveDado : write data
//   LeDado      : registered read data, changes only on a completed read
//   Pronto      : one-cycle access-complete strobe
//   Erro        : strobe for both requests high in IDLE
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              EscMem,
  input  logic              LerMem,
  input  logic [ADDR_W-1:0] Endereco,
  input  logic [DATA_W-1:0] EscreveDado,
  output logic [DATA_W-1:0] LeDado,
  output logic              Pronto,
  output logic              Erro
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_STATES);

  mem_state_t        state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              pronto_q;
  logic              erro_q;

  logic              access_d;
  logic              mem_we_d;
  logic              mem_re_d;

  // The access happens on the last BUSY edge, using the latched request.
  assign access_d = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we_d = access_d && wr_q;
  assign mem_re_d = access_d && !wr_q;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (EscMem && LerMem) begin
            // Ambiguous request: flag it and latch nothing.
            erro_q <= 1'b1;
          end else if (EscMem || LerMem) begin
            wr_q    <= EscMem;
            addr_q  <= Endereco;
            data_q  <= EscreveDado;
            cnt_q   <= WAIT_LD;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            pronto_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // A request still high here is the one just serviced.
          state_q <= (EscMem || LerMem) ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!EscMem && !LerMem) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk_i  (Clock),
    .rst_ni (reset),
    .we_i   (mem_we_d),
    .re_i   (mem_re_d),
    .addr_i (addr_q),
    .wdata_i(data_q),
    .rdata_o(LeDado)
  );

  assign Pronto = pronto_q;
  assign Erro   = erro_q;

endmodule
